// File: rtl/alu_sel_pkg.sv
// Shared opcode constants and beat layout for the registered ALU result selector.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_sel_pkg;

    // Opcodes understood by the selector; every other 3-bit code is illegal.
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b011;

    // Flag bits carried alongside the data word in every beat.
    typedef struct packed {
        logic zero;
        logic illegal;
    } beat_flags_t;

    localparam int BEAT_FLAG_W = $bits(beat_flags_t);

    // Total beat width for a given data width: {data, zero, illegal}.
    function automatic int beat_w(input int width);
        return width + BEAT_FLAG_W;
    endfunction

    // True for the four opcodes that select a real ALU result.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready buffer: a main register driving the outputs plus one skid register.
// Latency: 1 cycle from accept to out_vld when empty; 1 beat/cycle sustained with out_rdy high.
// Backpressure: in_rdy is a flop (!skid valid), so there is no combinational out_rdy -> in_rdy path.
module skid_buf2 #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_dat
);

    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic              acc;
    logic              xfer;

    assign acc     = in_vld && in_rdy;
    assign xfer    = main_vld && out_rdy;
    assign in_rdy  = !skid_vld;
    assign out_vld = main_vld;
    assign out_dat = main_dat;

    // Main/skid occupancy and data; the skid only fills while main is stalled,
    // and always drains into main before any newer beat so ordering is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (!main_vld) begin
            if (acc) begin
                main_vld <= 1'b1;
                main_dat <= in_dat;
            end
        end else if (xfer) begin
            if (skid_vld) begin
                // in_rdy is low while skid is full, so no accept can coincide here.
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (acc) begin
                main_dat <= in_dat;
            end else begin
                // Data is left in place so the outputs hold their last value.
                main_vld <= 1'b0;
            end
        end else if (acc) begin
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// Registered ALU result selector: decodes a 3-bit opcode into one of four results, flags zero/illegal, counts illegal opcodes.
// Latency: 1 cycle from accept to OutValid when empty; 1 beat/cycle with OutReady held high.
// Backpressure: 2-entry skid buffer; InReady drops the cycle after the skid fills and is never combinational on OutReady.
module alu_result_sel_pipe #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Hyrja0,
    input  logic [WIDTH-1:0] Hyrja1,
    input  logic [WIDTH-1:0] Hyrja2,
    input  logic [WIDTH-1:0] Hyrja3,
    input  logic [2:0]       S,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Illegal,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [CNT_W-1:0] ErrCount,
    input  logic             ErrClr
);

    import alu_sel_pkg::*;

    localparam int BW = beat_w(WIDTH);

    logic [WIDTH-1:0] sel_data;
    beat_flags_t      in_flags;
    beat_flags_t      out_flags;
    logic [BW-1:0]    in_beat;
    logic [BW-1:0]    out_beat;
    logic             acc;
    logic [CNT_W-1:0] err_cnt;

    // Opcode decode; illegal codes produce data 0 so nothing downstream ever sees X.
    always_comb begin
        sel_data = '0;
        case (S)
            OP_AND:  sel_data = Hyrja0;
            OP_OR:   sel_data = Hyrja1;
            OP_ADD:  sel_data = Hyrja2;
            OP_XOR:  sel_data = Hyrja3;
            default: sel_data = '0;
        endcase
    end

    assign in_flags.zero    = (sel_data == '0);
    assign in_flags.illegal = !op_is_legal(S);
    assign in_beat          = {sel_data, in_flags};
    assign acc              = InValid && InReady;

    skid_buf2 #(
        .DATA_W (BW)
    ) u_skid (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .in_vld  (InValid),
        .in_rdy  (InReady),
        .in_dat  (in_beat),
        .out_vld (OutValid),
        .out_rdy (OutReady),
        .out_dat (out_beat)
    );

    assign out_flags = out_beat[BEAT_FLAG_W-1:0];
    assign Out       = out_beat[BW-1 -: WIDTH];
    assign Zero      = out_flags.zero;
    assign Illegal   = out_flags.illegal;

    // Saturating illegal-opcode counter, bumped at input acceptance; clear wins over increment.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            err_cnt <= '0;
        end else if (ErrClr) begin
            err_cnt <= '0;
        end else if (acc && in_flags.illegal && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign ErrCount = err_cnt;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Randomized self-checking bench: a queue-based model of the selector pipe plus a CNT_W=2 instance for saturation.
// Latency: expects 1 cycle accept-to-output.
// Backpressure: model holds up to two beats; InReady expected whenever fewer than two are held.
module tb_alu_result_sel_pipe;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] Hyrja0 = '0, Hyrja1 = '0, Hyrja2 = '0, Hyrja3 = '0;
    logic [2:0]  S = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [15:0] Out;
    logic        Zero, Illegal, OutValid;
    logic        OutReady = 1'b0;
    logic [7:0]  ErrCount;
    logic        ErrClr = 1'b0;

    // Second instance with a 2-bit counter for the saturation checks.
    logic [2:0]  s2_s = '0;
    logic        s2_inv = 1'b0;
    logic        s2_clr = 1'b0;
    logic        s2_inrdy, s2_zero, s2_ill, s2_ovld;
    logic [15:0] s2_out;
    logic [1:0]  s2_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q[$];
    int          mcnt = 0;

    always #5 Clock = ~Clock;

    alu_result_sel_pipe #(.WIDTH(16), .CNT_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Hyrja0(Hyrja0), .Hyrja1(Hyrja1), .Hyrja2(Hyrja2), .Hyrja3(Hyrja3),
        .S(S), .InValid(InValid), .InReady(InReady),
        .Out(Out), .Zero(Zero), .Illegal(Illegal), .OutValid(OutValid),
        .OutReady(OutReady), .ErrCount(ErrCount), .ErrClr(ErrClr)
    );

    alu_result_sel_pipe #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .Clock(Clock), .Reset_n(Reset_n),
        .Hyrja0(16'h1111), .Hyrja1(16'h2222), .Hyrja2(16'h3333), .Hyrja3(16'h4444),
        .S(s2_s), .InValid(s2_inv), .InReady(s2_inrdy),
        .Out(s2_out), .Zero(s2_zero), .Illegal(s2_ill), .OutValid(s2_ovld),
        .OutReady(1'b1), .ErrCount(s2_cnt), .ErrClr(s2_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference result for an opcode: {data, zero, illegal}.
    function automatic logic [17:0] ref_beat(input logic [2:0] s, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] c,
                                             input logic [15:0] d);
        logic [15:0] v;
        logic        ill;
        ill = 1'b0;
        if (s == 3'd0)      v = a;
        else if (s == 3'd2) v = b;
        else if (s == 3'd4) v = c;
        else if (s == 3'd3) v = d;
        else begin
            v   = 16'h0;
            ill = 1'b1;
        end
        return {v, (v == 16'h0), ill};
    endfunction

    task automatic check_outputs();
        chk("in_ready",  32'(InReady),  32'(q.size() < 2));
        chk("out_valid", 32'(OutValid), 32'(q.size() != 0));
        chk("err_count", 32'(ErrCount), 32'(mcnt));
        if (q.size() != 0) begin
            chk("out",     32'(Out),     32'(q[0][17:2]));
            chk("zero",    32'(Zero),    32'(q[0][1]));
            chk("illegal", 32'(Illegal), 32'(q[0][0]));
        end
    endtask

    // One cycle: check what the last edge produced, drive new inputs, advance the model.
    task automatic step(input logic iv, input logic [2:0] s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] c, input logic [15:0] d,
                        input logic ordy, input logic clr);
        logic [17:0] bt;
        logic        m_acc;
        logic        m_xfer;
        @(negedge Clock);
        check_outputs();
        InValid  = iv;
        S        = s;
        Hyrja0   = a;
        Hyrja1   = b;
        Hyrja2   = c;
        Hyrja3   = d;
        OutReady = ordy;
        ErrClr   = clr;
        bt       = ref_beat(s, a, b, c, d);
        m_acc    = iv && (q.size() < 2);
        m_xfer   = ordy && (q.size() != 0);
        if (m_xfer) void'(q.pop_front());
        if (m_acc) q.push_back(bt);
        if (clr) mcnt = 0;
        else if (m_acc && bt[0] && mcnt < 255) mcnt++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, ordy, 1'b0);
    endtask

    initial begin
        // Reset state.
        #2;
        chk("rst_out_valid", 32'(OutValid), 32'd0);
        chk("rst_out",       32'(Out),      32'd0);
        chk("rst_zero",      32'(Zero),     32'd0);
        chk("rst_illegal",   32'(Illegal),  32'd0);
        chk("rst_err_count", 32'(ErrCount), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;

        // Single AND beat, one cycle latency.
        step(1'b1, 3'b000, 16'h00F0, 16'h1234, 16'h5678, 16'h9ABC, 1'b1, 1'b0);
        @(posedge Clock); #1;
        chk("t1_out",   32'(Out),      32'h00F0);
        chk("t1_valid", 32'(OutValid), 32'd1);
        chk("t1_zero",  32'(Zero),     32'd0);
        chk("t1_ill",   32'(Illegal),  32'd0);

        // Back-to-back OR, ADD, XOR.
        step(1'b1, 3'b010, 16'hAAAA, 16'h0101, 16'hBBBB, 16'hCCCC, 1'b1, 1'b0);
        step(1'b1, 3'b100, 16'hAAAA, 16'hBBBB, 16'h0202, 16'hCCCC, 1'b1, 1'b0);
        step(1'b1, 3'b011, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0303, 1'b1, 1'b0);
        idle(1'b1);

        // Illegal opcodes and counter clear.
        step(1'b1, 3'b111, 16'h1, 16'h2, 16'h3, 16'h4, 1'b1, 1'b0);
        step(1'b1, 3'b001, 16'h1, 16'h2, 16'h3, 16'h4, 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        idle(1'b1);
        chk("clr_err_count", 32'(ErrCount), 32'd0);

        // Stall: A in main, B in skid, C waits, then drain in order.
        step(1'b1, 3'b000, 16'hA00A, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'b010, 16'h0, 16'hB00B, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 16'h0, 16'h0, 16'hC00C, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'b100, 16'h0, 16'h0, 16'hC00C, 16'h0, 1'b0, 1'b0);
        @(posedge Clock); #1;
        chk("stall_hold_out", 32'(Out),     32'hA00A);
        chk("stall_in_ready", 32'(InReady), 32'd0);
        step(1'b1, 3'b100, 16'h0, 16'h0, 16'hC00C, 16'h0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [15:0] r[4];
            for (int k = 0; k < 4; k++)
                r[k] = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            step($urandom_range(0, 9) < 7, 3'($urandom), r[0], r[1], r[2], r[3],
                 $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
        end

        // Mid-stream reset with main and skid full.
        step(1'b1, 3'b110, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'b000, 16'h7777, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 3'b010, 16'h0, 16'h8888, 16'h0, 16'h0, 1'b0, 1'b0);
        @(negedge Clock);
        check_outputs();
        InValid = 1'b0;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(OutValid), 32'd0);
        chk("mid_rst_out",   32'(Out),      32'd0);
        chk("mid_rst_zero",  32'(Zero),     32'd0);
        chk("mid_rst_ill",   32'(Illegal),  32'd0);
        q.delete();
        mcnt = 0;
        @(negedge Clock);
        Reset_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Saturation on the CNT_W=2 instance.
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            s2_s   = 3'b101;
            s2_inv = 1'b1;
            @(posedge Clock); #1;
            chk("sat_count", 32'(s2_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        @(negedge Clock);
        s2_clr = 1'b1;
        @(posedge Clock); #1;
        chk("sat_clr_wins", 32'(s2_cnt), 32'd0);
        @(negedge Clock);
        s2_clr = 1'b0;
        s2_inv = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
